// File: rtl/systolic_array_controller.sv
// Job sequencer for an ARRAY_DIM x ARRAY_DIM systolic PE grid: clear, feed, drain, row readout.
// Optional build macro SYSTOLIC_CTRL_PERF_EN adds busy-cycle and read-stall counters.
module systolic_array_controller #(
  parameter int ARRAY_DIM    = 4,
  parameter int K_WIDTH      = 8,
  parameter int DRAIN_CYCLES = 8,
  parameter int ROW_W        = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [K_WIDTH-1:0] i_k_len,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pe_clear,
  output logic [K_WIDTH-1:0] o_feed_idx,
  output logic               o_feed_valid,
  output logic               o_pe_done_flag,
  output logic [ROW_W-1:0]   o_rd_row,
  output logic               o_rd_valid,
  input  logic               i_rd_ready
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]        o_perf_cycles,
  output logic [15:0]        o_perf_stall
`endif
);

  // Counter is wide enough for k_len plus the full skew span without wrapping.
  localparam int CW = K_WIDTH + ROW_W + 1;
  localparam logic [CW-1:0]    SKEW_SPAN  = CW'(2 * (ARRAY_DIM - 1));
  localparam logic [CW-1:0]    DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ARRAY_DIM - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_READ  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [ROW_W-1:0]   r_row, w_row_nxt;
  logic [K_WIDTH-1:0] r_k, w_k_nxt;
  logic [CW-1:0]      w_feed_last;
  logic               w_in_feed;
  logic               w_feed_live;
  logic [K_WIDTH-1:0] w_feed_idx;

  assign w_feed_last = CW'(r_k) + SKEW_SPAN - CW'(1'b1);
  assign o_rd_row    = r_row;

  // Next-state and counter sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row;
    w_k_nxt     = r_k;
    case (r_state)
      ST_IDLE: begin
        if (i_start && (i_k_len != {K_WIDTH{1'b0}})) begin
          w_state_nxt = ST_CLEAR;
          w_k_nxt     = i_k_len;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_FEED;
        w_cnt_nxt   = {CW{1'b0}};
      end
      ST_FEED: begin
        if (r_cnt == w_feed_last) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_cnt_nxt = r_cnt + CW'(1'b1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_state_nxt = ST_READ;
          w_cnt_nxt   = {CW{1'b0}};
          w_row_nxt   = {ROW_W{1'b0}};
        end else begin
          w_cnt_nxt = r_cnt + CW'(1'b1);
        end
      end
      ST_READ: begin
        if (i_rd_ready) begin
          if (r_row == ROW_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_row_nxt = r_row + ROW_W'(1'b1);
          end
        end else begin
          w_row_nxt = r_row;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_row_nxt   = {ROW_W{1'b0}};
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {CW{1'b0}};
        w_row_nxt   = {ROW_W{1'b0}};
      end
    endcase
  end

  // Feed outputs decoded from the upcoming state so they can be registered.
  always_comb begin
    w_in_feed   = (w_state_nxt == ST_FEED);
    w_feed_live = w_in_feed && (w_cnt_nxt < CW'(r_k));
    if (!w_in_feed) begin
      w_feed_idx = {K_WIDTH{1'b0}};
    end else if (w_feed_live) begin
      w_feed_idx = w_cnt_nxt[K_WIDTH-1:0];
    end else begin
      w_feed_idx = r_k - 1'b1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= {CW{1'b0}};
      r_row          <= {ROW_W{1'b0}};
      r_k            <= {K_WIDTH{1'b0}};
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_pe_clear     <= 1'b0;
      o_feed_idx     <= {K_WIDTH{1'b0}};
      o_feed_valid   <= 1'b0;
      o_pe_done_flag <= 1'b0;
      o_rd_valid     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_row          <= w_row_nxt;
      r_k            <= w_k_nxt;
      o_busy         <= (w_state_nxt != ST_IDLE);
      o_done         <= (w_state_nxt == ST_DONE);
      o_pe_clear     <= (w_state_nxt == ST_CLEAR);
      o_feed_idx     <= w_feed_idx;
      o_feed_valid   <= w_feed_live;
      o_pe_done_flag <= w_in_feed && (w_cnt_nxt == w_feed_last);
      o_rd_valid     <= (w_state_nxt == ST_READ);
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic w_accept;
  assign w_accept = (r_state == ST_IDLE) && (w_state_nxt == ST_CLEAR);

  // Saturating job-cycle and read-stall counters, cleared when a job is accepted.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_accept) begin
      o_perf_cycles <= 32'h0000_0000;
      o_perf_stall  <= 16'h0000;
    end else begin
      if (o_busy && (o_perf_cycles != 32'hFFFF_FFFF)) begin
        o_perf_cycles <= o_perf_cycles + 32'd1;
      end
      if ((r_state == ST_READ) && !i_rd_ready && (o_perf_stall != 16'hFFFF)) begin
        o_perf_stall <= o_perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/systolic_array_controller.md
Name: systolic_array_controller

Overview:
- Sequences one matrix-multiply job on an ARRAY_DIM x ARRAY_DIM grid of floating-point processing elements (PEs).
- Clears the PEs, then drives operand feed indices and the skew-flush window, then raises the PE done flag.
- Waits out the PE float reduction/drain latency, then hands accumulated rows to the result collector over a valid/ready handshake.
- Sits between the host command interface and the PE array plus its edge feeders.

Parameters:
ARRAY_DIM, 4, PE rows/columns; feeder skew = ARRAY_DIM-1 cycles.
K_WIDTH, 8, width of inner-dimension length and feed index.
DRAIN_CYCLES, 8, cycles from pe_done_flag to valid out_c in every PE; must be >= 1.
ROW_W, $clog2(ARRAY_DIM) (min 1), width of rd_row.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  job request; sampled only in IDLE.
k_len  in  K_WIDTH  inner-dimension length; sampled with start.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at job end.
pe_clear  out  1  one-cycle PE reset pulse at job begin.
feed_idx  out  K_WIDTH  operand buffer index for the edge feeders.
feed_valid  out  1  feed_idx is a real operand; low means feeders inject zero.
pe_done_flag  out  1  drives in_done_flag of all PEs; one-cycle pulse.
rd_row  out  ROW_W  PE row currently presented to the collector.
rd_valid  out  1  row rd_row is readable.
rd_ready  in  1  collector accepts the row.

Behaviour:
- Reset: state=IDLE. busy, done, pe_clear, feed_valid, pe_done_flag and rd_valid are 0; feed_idx=0, rd_row=0; all counters 0. Reset in any state aborts the job the next cycle, with no done pulse.
- IDLE:
  - start=1 with k_len!=0: latch k_len, go to CLEAR.
  - start=1 with k_len==0: ignored; stay in IDLE, busy stays 0.
- CLEAR: one cycle; pe_clear=1. Go to FEED with cnt=0.
- FEED: lasts F = k_len + 2*(ARRAY_DIM-1) cycles; cnt counts 0..F-1.
  - feed_idx = cnt while cnt<k_len, else it holds k_len-1.
  - feed_valid = (cnt<k_len).
  - On cnt==F-1: pe_done_flag=1, then go to DRAIN.
  - Width rule: cnt is K_WIDTH+ROW_W+1 bits, so F never wraps, including at k_len = 2^K_WIDTH-1.
- DRAIN: exactly DRAIN_CYCLES cycles; all PE-facing outputs are 0. Then go to READ with rd_row=0.
- READ:
  - rd_valid=1.
  - On rd_valid&&rd_ready: if rd_row==ARRAY_DIM-1, go to DONE; else rd_row+1.
  - rd_ready low stalls indefinitely; rd_row is held stable while stalled.
- DONE: one cycle; done=1, busy=1. Then go to IDLE; rd_row returns to 0.
- start while busy: ignored, with no queuing. start asserted in the DONE cycle is also ignored. start asserted in the cycle after DONE (IDLE) is accepted.
- All outputs are registered, decoded from state/counters; no combinational path from input to output.
- Latency, start edge to done pulse, with rd_ready held high: 1 + F + DRAIN_CYCLES + ARRAY_DIM + 1 cycles.

Optional Feature:
Macro: SYSTOLIC_CTRL_PERF_EN
- Defined:
  - Adds output perf_cycles, 32 bits.
  - Counter clears on job accept and increments every cycle busy=1, saturating at 0xFFFFFFFF.
  - It holds its value after DONE until the next accepted start.
  - Reset clears it to 0.
  - Adds output perf_stall, 16 bits, saturating, counting READ cycles with rd_ready=0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Nominal, ARRAY_DIM=4, DRAIN_CYCLES=8, k_len=5, rd_ready=1, start at edge T0:
  - pe_clear at T1.
  - feed_valid T2..T6 with feed_idx 0..4.
  - feed_valid=0 T7..T12; pe_done_flag at T12.
  - rd_valid T21..T24 with rd_row 0..3.
  - done at T25; busy T1..T25.
- Backpressure: same job with rd_ready=0 for 3 cycles while rd_row=1 -> rd_row held at 1, rd_valid held at 1, done at T28; with the macro, perf_stall=3 and perf_cycles=28.
- k_len=0 with start=1 -> busy stays 0, no pe_clear, and no output changes.
- Ignored start:
  - start pulsed during FEED -> timing identical to the nominal case.
  - start asserted in the DONE cycle (T25) -> ignored.
  - start re-asserted at T26 -> pe_clear at T27.
- Reset mid-operation: reset at T15 (DRAIN) -> at T16 busy=0, rd_valid=0, no done pulse; a new start then gives nominal timing.
- Large k_len=255, ARRAY_DIM=4:
  - Exactly 255 feed_valid cycles, with feed_idx 0..254.
  - F=261; pe_done_flag at T262.
  - No counter wrap.
